// File: rtl/mux_scheduler_if.sv
// -----------------------------------------------------------------------------
// mux_scheduler_if
// Bundles the signals between mux_scheduler and its neighbours: the
// driver_controller handshake (clk_enable, driver_ready, column_ready,
// position_sync), the rotation sensor input, the fpga_mul row enables and the
// row/slice indices consumed by the framebuffer read logic.
//
// Modports:
//   slave  - the scheduler itself (consumes handshake inputs, drives outputs)
//   master - the environment (drives handshake inputs, observes outputs)
// -----------------------------------------------------------------------------
interface mux_scheduler_if #(
  parameter int NB_MUX    = 8,
  parameter int NB_SLICES = 256
);
  localparam int MUX_W   = $clog2(NB_MUX);
  localparam int SLICE_W = $clog2(NB_SLICES);

  logic               clk_enable;
  logic               driver_ready;
  logic               column_ready;
  logic               position_in;
  logic               position_sync;
  logic [NB_MUX-1:0]  fpga_mul;
  logic [MUX_W-1:0]   mux_index;
  logic [SLICE_W-1:0] slice_index;
  logic               turn_done;
  logic               overrun;

  modport slave (
    input  clk_enable, driver_ready, column_ready, position_in,
    output position_sync, fpga_mul, mux_index, slice_index, turn_done, overrun
  );

  modport master (
    output clk_enable, driver_ready, column_ready, position_in,
    input  position_sync, fpga_mul, mux_index, slice_index, turn_done, overrun
  );
endinterface

// File: rtl/mux_scheduler.sv
// -----------------------------------------------------------------------------
// mux_scheduler
// Drives the LED multiplex transistors in step with driver_controller. Every
// column_ready blanks all rows for DEAD_TIME clk_enable ticks, then enables the
// next row one-hot. Tracks the multiplex row and the angular slice, and
// realigns both to zero at the first row advance after a rotation sensor edge.
//
// Ports:
//   clk   - system clock
//   nrst  - asynchronous active-low reset
//   bus   - mux_scheduler_if.slave:
//           clk_enable    in  tick qualifier for the dead-time counter
//           driver_ready  in  driver_controller is streaming
//           column_ready  in  one-clk pulse, new column latched in drivers
//           position_in   in  rotation sensor level, synchronous to clk
//           position_sync out one-clk pulse on realignment
//           fpga_mul      out one-hot row enable, zero while blanking/idle
//           mux_index     out row enabled or about to be enabled
//           slice_index   out current angular slice
//           turn_done     out one-clk pulse on slice wrap or realignment
//           overrun       out sticky: column_ready arrived while blanking
// Assumes NB_MUX and NB_SLICES are powers of two >= 2.
// -----------------------------------------------------------------------------
module mux_scheduler #(
  parameter int NB_MUX    = 8,
  parameter int NB_SLICES = 256,
  parameter int DEAD_TIME = 4
) (
  input  logic          clk,
  input  logic          nrst,
  mux_scheduler_if.slave bus
);
  localparam int MUX_W   = $clog2(NB_MUX);
  localparam int SLICE_W = $clog2(NB_SLICES);

  localparam logic [7:0]         DEAD_LOAD  = 8'(DEAD_TIME);
  localparam logic [MUX_W-1:0]   MUX_LAST   = MUX_W'(NB_MUX - 1);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NB_SLICES - 1);
  localparam logic [NB_MUX-1:0]  MUL_ONE    = NB_MUX'(1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         dead_q, dead_d;
  logic [MUX_W-1:0]   mux_q, mux_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic [NB_MUX-1:0]  mul_q, mul_d;
  logic               pend_q, pend_d;
  logic               pos_q;
  logic               psync_q, psync_d;
  logic               turn_q, turn_d;
  logic               ovr_q, ovr_d;

  logic pos_rise;
  logic pend_eff;

  assign pos_rise = bus.position_in & ~pos_q;
  // An edge arriving on the same clk as the advance is honoured by that advance.
  assign pend_eff = pend_q | pos_rise;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    dead_d  = dead_q;
    mux_d   = mux_q;
    slice_d = slice_q;
    mul_d   = mul_q;
    pend_d  = pend_eff;
    psync_d = 1'b0;
    turn_d  = 1'b0;
    ovr_d   = ovr_q;

    if (!bus.driver_ready) begin
      // Losing the driver stops the rows at once; indices and pending sync hold.
      state_d = IDLE;
      mul_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          dead_d  = DEAD_LOAD;
          mul_d   = '0;
        end

        BLANK: begin
          mul_d = '0;
          if (bus.column_ready) ovr_d = 1'b1;
          if (bus.clk_enable) begin
            if (dead_q <= 8'd1) begin
              state_d = ON;
              dead_d  = '0;
              mul_d   = MUL_ONE << mux_q;
            end else begin
              dead_d = dead_q - 8'd1;
            end
          end
        end

        ON: begin
          if (bus.column_ready) begin
            state_d = BLANK;
            dead_d  = DEAD_LOAD;
            mul_d   = '0;
            if (pend_eff) begin
              mux_d   = '0;
              slice_d = '0;
              pend_d  = 1'b0;
              psync_d = 1'b1;
              turn_d  = 1'b1;
            end else if (mux_q == MUX_LAST) begin
              mux_d = '0;
              if (slice_q == SLICE_LAST) begin
                slice_d = '0;
                turn_d  = 1'b1;
              end else begin
                slice_d = slice_q + 1'b1;
              end
            end else begin
              mux_d = mux_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          mul_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      dead_q  <= '0;
      mux_q   <= '0;
      slice_q <= '0;
      mul_q   <= '0;
      pend_q  <= 1'b0;
      pos_q   <= 1'b0;
      psync_q <= 1'b0;
      turn_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      mux_q   <= mux_d;
      slice_q <= slice_d;
      mul_q   <= mul_d;
      pend_q  <= pend_d;
      pos_q   <= bus.position_in;
      psync_q <= psync_d;
      turn_q  <= turn_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.fpga_mul      = mul_q;
  assign bus.mux_index     = mux_q;
  assign bus.slice_index   = slice_q;
  assign bus.position_sync = psync_q;
  assign bus.turn_done     = turn_q;
  assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_mux_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux_scheduler
// Directed bench for mux_scheduler (NB_MUX=8, NB_SLICES=4, DEAD_TIME=4).
// A table of row advances walks the rows through a full slice wrap and a
// sensor realignment; hand-written sequences cover coincident sensor edges,
// overrun, gated dead time, driver loss and asynchronous reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mux_scheduler;
  localparam int NB_MUX    = 8;
  localparam int NB_SLICES = 4;
  localparam int DEAD_TIME = 4;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  mux_scheduler_if #(.NB_MUX(NB_MUX), .NB_SLICES(NB_SLICES)) bus ();

  mux_scheduler #(
    .NB_MUX   (NB_MUX),
    .NB_SLICES(NB_SLICES),
    .DEAD_TIME(DEAD_TIME)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int turn_cnt = 0;
  int sync_cnt = 0;

  typedef struct {
    bit pos;        // pulse position_in before this advance
    int exp_mux;
    int exp_slice;
    bit exp_turn;
    bit exp_sync;
  } vec_t;

  vec_t vecs[55];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse counters and the one-hot invariant, watched every cycle.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (bus.turn_done === 1'b1) turn_cnt++;
      if (bus.position_sync === 1'b1) sync_cnt++;
      if ($countones(bus.fpga_mul) > 1) begin
        errors++;
        $display("FAIL onehot: fpga_mul=%b", bus.fpga_mul);
      end
    end
  end

  // Counts blank cycles starting at the current falling edge; optionally
  // toggles clk_enable every cycle. Bounded at 100 cycles.
  task automatic count_blank(input bit toggle, output int zeros);
    zeros = 0;
    while (bus.fpga_mul == '0 && zeros < 100) begin
      zeros++;
      if (toggle) bus.clk_enable = ~bus.clk_enable;
      tick();
    end
  endtask

  // One-clk column_ready; returns the outputs seen in the cycle after the edge.
  task automatic column_pulse(output logic turn, output logic sync,
                              output logic [31:0] mux, output logic [31:0] slice);
    bus.column_ready = 1'b1;
    tick();
    bus.column_ready = 1'b0;
    turn  = bus.turn_done;
    sync  = bus.position_sync;
    mux   = 32'(bus.mux_index);
    slice = 32'(bus.slice_index);
  endtask

  initial begin
    int          zeros;
    logic        turn, sync;
    logic [31:0] mux, slice;

    // Advance table: 53 plain advances from row 0 (includes the 32nd, which
    // wraps the slice), then a sensor-realigned advance at mux 5 / slice 2,
    // then one plain advance.
    for (int i = 0; i < 53; i++)
      vecs[i] = '{1'b0, (i + 1) % 8, ((i + 1) / 8) % 4, ((i + 1) % 32) == 0, 1'b0};
    vecs[53] = '{1'b1, 0, 0, 1'b1, 1'b1};
    vecs[54] = '{1'b0, 1, 0, 1'b0, 1'b0};

    // ---- reset, then idle with driver_ready low ----
    nrst             = 1'b0;
    bus.clk_enable   = 1'b1;
    bus.driver_ready = 1'b0;
    bus.column_ready = 1'b0;
    bus.position_in  = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    repeat (5) tick();
    bus.column_ready = 1'b1;   // ignored in IDLE
    tick();
    bus.column_ready = 1'b0;
    repeat (10) tick();
    check("idle_fpga_mul", 32'(bus.fpga_mul), 0);
    check("idle_mux", 32'(bus.mux_index), 0);
    check("idle_slice", 32'(bus.slice_index), 0);
    check("idle_sync", 32'(bus.position_sync), 0);
    check("idle_turn", 32'(bus.turn_done), 0);
    check("idle_overrun", 32'(bus.overrun), 0);

    // ---- first enable ----
    bus.driver_ready = 1'b1;
    tick();
    count_blank(1'b0, zeros);
    check("start_blank_len", zeros, DEAD_TIME);
    check("start_fpga_mul", 32'(bus.fpga_mul), 32'h01);
    check("start_mux", 32'(bus.mux_index), 0);

    // ---- table of row advances ----
    foreach (vecs[i]) begin
      if (vecs[i].pos) begin
        bus.position_in = 1'b1;
        repeat (3) tick();
        bus.position_in = 1'b0;
        repeat (2) tick();
      end
      column_pulse(turn, sync, mux, slice);
      check($sformatf("v%0d_mux", i), mux, vecs[i].exp_mux);
      check($sformatf("v%0d_slice", i), slice, vecs[i].exp_slice);
      check($sformatf("v%0d_turn", i), 32'(turn), 32'(vecs[i].exp_turn));
      check($sformatf("v%0d_sync", i), 32'(sync), 32'(vecs[i].exp_sync));
      check($sformatf("v%0d_fpga_blank", i), 32'(bus.fpga_mul), 0);
      count_blank(1'b0, zeros);
      check($sformatf("v%0d_blank_len", i), zeros, DEAD_TIME);
      check($sformatf("v%0d_fpga_mul", i), 32'(bus.fpga_mul), 32'(1) << vecs[i].exp_mux);
      repeat (12) tick();
      if (i == 31) check("wrap_turn_pulses", turn_cnt, 1);
    end
    check("table_turn_pulses", turn_cnt, 2);
    check("table_sync_pulses", sync_cnt, 1);

    // ---- sensor edge coincident with column_ready ----
    bus.position_in = 1'b1;
    column_pulse(turn, sync, mux, slice);
    bus.position_in = 1'b0;
    check("coinc_mux", mux, 0);
    check("coinc_slice", slice, 0);
    check("coinc_sync", 32'(sync), 1);
    check("coinc_turn", 32'(turn), 1);
    count_blank(1'b0, zeros);
    check("coinc_fpga_mul", 32'(bus.fpga_mul), 32'h01);
    repeat (5) tick();
    column_pulse(turn, sync, mux, slice);
    check("after_coinc_mux", mux, 1);
    check("after_coinc_sync", 32'(sync), 0);
    count_blank(1'b0, zeros);
    repeat (5) tick();

    // ---- column_ready during BLANK ----
    check("pre_overrun", 32'(bus.overrun), 0);
    column_pulse(turn, sync, mux, slice);
    check("ovr_adv_mux", mux, 2);
    bus.column_ready = 1'b1;
    tick();
    bus.column_ready = 1'b0;
    count_blank(1'b0, zeros);
    check("ovr_mux_held", 32'(bus.mux_index), 2);
    check("ovr_fpga_mul", 32'(bus.fpga_mul), 32'h04);
    check("ovr_flag", 32'(bus.overrun), 1);
    repeat (5) tick();

    // ---- dead time with clk_enable toggling ----
    bus.clk_enable = 1'b1;
    column_pulse(turn, sync, mux, slice);
    check("gated_mux", mux, 3);
    count_blank(1'b1, zeros);
    bus.clk_enable = 1'b1;
    check("gated_blank_len", zeros, 2 * DEAD_TIME);
    check("gated_fpga_mul", 32'(bus.fpga_mul), 32'h08);
    check("ovr_sticky", 32'(bus.overrun), 1);
    repeat (3) tick();

    // ---- driver_ready drop in ON at mux 3 ----
    bus.driver_ready = 1'b0;
    tick();
    check("drop_fpga_mul", 32'(bus.fpga_mul), 0);
    check("drop_mux", 32'(bus.mux_index), 3);
    repeat (5) tick();
    check("drop_fpga_mul_hold", 32'(bus.fpga_mul), 0);
    check("drop_mux_hold", 32'(bus.mux_index), 3);
    check("drop_overrun_hold", 32'(bus.overrun), 1);
    bus.driver_ready = 1'b1;
    tick();
    count_blank(1'b0, zeros);
    check("resume_blank_len", zeros, DEAD_TIME);
    check("resume_fpga_mul", 32'(bus.fpga_mul), 32'h08);
    repeat (3) tick();

    // ---- asynchronous reset mid-BLANK ----
    column_pulse(turn, sync, mux, slice);
    check("pre_reset_mux", mux, 4);
    tick();
    nrst = 1'b0;
    #1;
    check("rst_fpga_mul", 32'(bus.fpga_mul), 0);
    check("rst_mux", 32'(bus.mux_index), 0);
    check("rst_slice", 32'(bus.slice_index), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_sync", 32'(bus.position_sync), 0);
    check("rst_turn", 32'(bus.turn_done), 0);
    bus.driver_ready = 1'b0;
    tick();
    nrst = 1'b1;
    repeat (4) tick();
    check("post_rst_fpga_mul", 32'(bus.fpga_mul), 0);
    check("post_rst_mux", 32'(bus.mux_index), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scheduler.md
Name: mux_scheduler

Overview:
- Sequences the LED multiplexing transistors (fpga_mul) against driver_controller's column updates. Each column_ready means new grayscale data is latched for the next multiplex row.
- On each column_ready it blanks all mux outputs for a programmable dead time, then enables the next row one-hot.
- Tracks mux row and angular slice indices for the framebuffer, and re-aligns to slice 0 on the rotation position sensor.
- Sits between driver_controller, the framebuffer read logic and the fpga_mul_* pins.

Parameters:
- NB_MUX, 8: number of multiplex rows; width of fpga_mul.
- NB_SLICES, 256: angular slices per revolution.
- DEAD_TIME, 4: blanking length, counted in clk_enable ticks; legal range 1..255.

Ports:
- clk  in  1  system clock (33 MHz domain)
- nrst  in  1  asynchronous active-low reset
- clk_enable  in  1  tick qualifier shared with driver_controller
- driver_ready  in  1  driver_controller configured and streaming
- column_ready  in  1  one-clk pulse: new column latched in drivers
- position_in  in  1  rotation sensor pulse, already synchronous to clk, one or more clk wide
- position_sync  out  1  one-clk pulse to driver_controller on realignment
- fpga_mul  out  NB_MUX  one-hot row enable, all-zero while blanking or idle
- mux_index  out  $clog2(NB_MUX)  row currently enabled or about to be enabled
- slice_index  out  $clog2(NB_SLICES)  current angular slice
- turn_done  out  1  one-clk pulse when slice_index wraps or is realigned
- overrun  out  1  sticky error flag

Behaviour:
- Reset (nrst low, async): state IDLE, fpga_mul=0, mux_index=0, slice_index=0, position_sync=0, turn_done=0, overrun=0, dead counter=0, sync_pending=0. Reset mid-operation forces these values immediately.
- All outputs are registered.
- **IDLE:** fpga_mul=0. When driver_ready=1, go to BLANK and load the dead counter with DEAD_TIME.
- **BLANK:** fpga_mul=0.
  - The counter decrements on each clk where clk_enable=1.
  - When the counter is 1 and clk_enable=1, go to ON next cycle. fpga_mul becomes one-hot(mux_index) in that same cycle.
  - Blank length is exactly DEAD_TIME enable ticks.
- **ON:** fpga_mul = 1 << mux_index. On column_ready=1:
  - go to BLANK and reload the dead counter; fpga_mul=0 on the next cycle;
  - advance the indices on the same edge (see Index advance).
- **Index advance:**
  - If sync_pending=1: mux_index←0, slice_index←0, sync_pending←0, position_sync pulses 1 clk, turn_done pulses 1 clk.
  - Else if mux_index=NB_MUX-1: mux_index←0 and slice_index increments.
    - If slice_index=NB_SLICES-1, it wraps to 0 and turn_done pulses.
  - Else mux_index increments.
- **position_in:**
  - A rising edge (previous-cycle register) sets sync_pending.
  - It is applied only at the next index advance, never mid-row.
  - A rising edge coincident with an advance is applied at that advance.
  - Multiple edges before an advance collapse into one.
- **column_ready outside ON:** in BLANK it is dropped and overrun←1. In IDLE it is ignored.
- **driver_ready falling** in any state: go to IDLE next cycle, fpga_mul=0. Indices and sync_pending hold; overrun holds.
- clk_enable affects only the dead counter; column_ready and position_in are sampled every clk.
- fpga_mul never has more than one bit set, in any cycle.

Test Plan:
1. nrst low, then high with driver_ready=0 → fpga_mul=0, mux_index=0, slice_index=0, all pulses 0, state IDLE indefinitely.
2. NB_MUX=8, DEAD_TIME=4, clk_enable=1, driver_ready=1 → fpga_mul=0 for 4 cycles, then 8'b00000001.
   - column_ready pulse → next cycle fpga_mul=0 for 4 cycles, then 8'b00000010, mux_index=1.
3. Eight column_ready pulses spaced 20 clk apart → fpga_mul walks 0x01..0x80 then back to 0x01; slice_index goes 0→1 on the 8th pulse.
   - With NB_SLICES=4, 32 pulses → slice_index wraps to 0 and turn_done is high exactly 1 clk.
4. At mux_index=5, slice_index=2, pulse position_in for 3 clk, then column_ready → mux_index=0, slice_index=0, position_sync and turn_done each 1 clk on the same cycle, fpga_mul=0x01 after the dead time.
5. column_ready during BLANK → overrun=1 and stays 1; mux_index is unchanged by that pulse.
   - clk_enable toggling every other clk → blank lasts 8 clk for DEAD_TIME=4.
6. Deassert driver_ready while in ON at mux_index=3 → fpga_mul=0 next cycle and mux_index stays 3.
   - Reassert → DEAD_TIME blank, then fpga_mul=0x08.
   - Assert nrst mid-BLANK → all outputs return to reset values asynchronously.
